// File: rtl/debounce_scan_controller.sv
// Round-robin switch debouncer: one shared compare/count unit visits one channel per clock.
// Defining DEBOUNCE_SCAN_STICKY_EN adds the i_Clear/o_Changed sticky change flags.
module debounce_scan_controller #(
  parameter int  NUM_CH         = 4,
  parameter int  DEBOUNCE_LIMIT = 4,
  localparam int CH_W           = $clog2(NUM_CH)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Enable,
  input  logic [NUM_CH-1:0] i_Bouncy,
`ifdef DEBOUNCE_SCAN_STICKY_EN
  input  logic [NUM_CH-1:0] i_Clear,
  output logic [NUM_CH-1:0] o_Changed,
`endif
  output logic [NUM_CH-1:0] o_Debounced,
  output logic              o_Event_Valid,
  output logic [CH_W-1:0]   o_Event_Ch,
  output logic              o_Event_Level,
  output logic [CH_W-1:0]   o_Scan_Ch
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] meta_q, sync_q;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] deb_q, deb_d;
  logic              ev_valid_q, ev_valid_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d;
  logic              ev_level_q, ev_level_d;

  // Operands of the shared unit for the channel under the scan pointer.
  logic             vis_sync, vis_deb;
  logic [CNT_W-1:0] vis_cnt;
  assign vis_sync = sync_q[ptr_q];
  assign vis_deb  = deb_q[ptr_q];
  assign vis_cnt  = cnt_q[ptr_q];

  always_comb begin
    // NOTE: every target gets a hold/default value first so no path leaves it unassigned (no latch).
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    ev_valid_d = 1'b0;
    ev_ch_d    = ev_ch_q;
    ev_level_d = ev_level_q;
    if (i_Enable) begin
      ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      if (vis_sync == vis_deb) begin
        cnt_d[ptr_q] = '0;
      end else if (vis_cnt == CNT_MAX) begin
        deb_d[ptr_q] = vis_sync;
        cnt_d[ptr_q] = '0;
        ev_valid_d   = 1'b1;
        ev_ch_d      = ptr_q;
        ev_level_d   = vis_sync;
      end else begin
        cnt_d[ptr_q] = vis_cnt + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q     <= '0;
      sync_q     <= '0;
      ptr_q      <= '0;
      // NOTE: the counter array is small flop storage, not RAM, so it is reset with everything else.
      cnt_q      <= '{default: '0};
      deb_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_level_q <= 1'b0;
    end else begin
      meta_q     <= i_Bouncy;
      sync_q     <= meta_q;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
      ev_level_q <= ev_level_d;
    end
  end

  assign o_Debounced   = deb_q;
  assign o_Event_Valid = ev_valid_q;
  assign o_Event_Ch    = ev_ch_q;
  assign o_Event_Level = ev_level_q;
  assign o_Scan_Ch     = ptr_q;

`ifdef DEBOUNCE_SCAN_STICKY_EN
  logic [NUM_CH-1:0] changed_q, changed_d;

  // Set is applied after clear so a same-cycle event keeps its flag.
  always_comb begin
    changed_d = changed_q & ~i_Clear;
    if (ev_valid_d) changed_d[ptr_q] = 1'b1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) changed_q <= '0;
    else          changed_q <= changed_d;
  end

  assign o_Changed = changed_q;
`endif

endmodule

// File: doc/debounce_scan_controller.md
# debounce_scan_controller

Time-multiplexed debounce controller for a bank of mechanical switch inputs. One shared compare/increment unit is scheduled round-robin across `NUM_CH` synchronized inputs, with per-channel stability counters and stable-state registers held locally. The block sits between the board switch pins and user logic. It produces a debounced level vector and a single change-event stream. Because only one channel is evaluated per clock, at most one event fires per cycle.

## Interface
- `NUM_CH`, 4: number of switch channels; legal range is 2 or more.
- `DEBOUNCE_LIMIT`, 4: consecutive disagreeing visits needed to accept a new level; legal range is 1 or more.
- `i_Clk`  in  1  system clock.
- `i_Rst_L`  in  1  reset; one clock; reset is asynchronous and active-low.
- `i_Enable`  in  1  scan enable; low freezes the scan pointer and all counters.
- `i_Bouncy`  in  NUM_CH  raw asynchronous switch inputs.
- `o_Debounced`  out  NUM_CH  accepted stable levels.
- `o_Event_Valid`  out  1  one-cycle pulse when any channel changes its accepted level.
- `o_Event_Ch`  out  CH_W  index of the changed channel; CH_W = $clog2(NUM_CH).
- `o_Event_Level`  out  1  new level of that channel.
- `o_Scan_Ch`  out  CH_W  channel being visited this cycle.
- `i_Clear`  in  NUM_CH  write-1-to-clear for the sticky flags; present only with the macro.
- `o_Changed`  out  NUM_CH  sticky change flags; present only with the macro.

## Operation
- **Synchronizer:** a 2-FF synchronizer per channel produces `sync[c]`. It runs every cycle, regardless of `i_Enable`.
- **Scan pointer:**
  - `ptr` advances 0→1→…→NUM_CH-1→0, one step per clock while `i_Enable`=1.
  - `o_Scan_Ch` = `ptr`.
- **Visit of channel c** (a clock edge with `ptr`==c and `i_Enable`=1):
  - If `sync[c]` == `o_Debounced[c]`: `cnt[c]` ← 0.
  - Else, if `cnt[c]` == DEBOUNCE_LIMIT-1: `o_Debounced[c]` ← `sync[c]`, `cnt[c]` ← 0, and an event is raised with `o_Event_Ch`=c and `o_Event_Level`=`sync[c]`.
  - Else: `cnt[c]` ← `cnt[c]`+1.
- **Counter width:** `cnt` is $clog2(DEBOUNCE_LIMIT+1) bits. It never exceeds DEBOUNCE_LIMIT-1 and never wraps.
- **Glitch rejection:** any agreeing visit resets the count. A bounce that lasts fewer than DEBOUNCE_LIMIT consecutive visits is therefore ignored.
- **DEBOUNCE_LIMIT=1:** the first disagreeing visit is accepted immediately.
- **Event uniqueness:** only one channel is visited per cycle, so simultaneous events cannot occur and no arbitration is needed.
- **Non-visited channels:** their `cnt` and `o_Debounced` hold.
- **`i_Enable`=0:**
  - `ptr`, all `cnt` and `o_Debounced` hold.
  - `o_Event_Valid`=0.
  - Scanning resumes from the held `ptr`.
- **Reset, at any time including mid-count:** all state is cleared asynchronously (`sync`, `cnt`, `ptr`, `o_Debounced`, event outputs and, if present, `o_Changed`).

## Timing
- **Output registers:** all outputs are registered. `o_Debounced[c]`, `o_Event_Valid`, `o_Event_Ch` and `o_Event_Level` update on the same edge, the accepting visit edge.
- **Event pulse:**
  - `o_Event_Valid` is high for exactly one cycle.
  - `o_Event_Ch` and `o_Event_Level` are valid only while `o_Event_Valid`=1; they hold their last value otherwise.
- **Reset values:** every output is 0 (`o_Debounced`=0, `o_Event_Valid`=0, `o_Event_Ch`=0, `o_Event_Level`=0, `o_Scan_Ch`=0, `o_Changed`=0).
- **Latency:** `i_Bouncy[c]` changes via a nonblocking assignment at edge E0 and then stays stable, with `i_Enable`=1 throughout.
  - The synchronized value is first sampled at edge E0+3.
  - Acceptance happens at edge E0+3+(DEBOUNCE_LIMIT-1)·NUM_CH+k, where k ∈ [0, NUM_CH-1] depends on `ptr` phase.
  - For NUM_CH=4 and DEBOUNCE_LIMIT=4, this is edge E0+15 … E0+18.

## Configuration
- **`DEBOUNCE_SCAN_STICKY_EN` defined:**
  - `o_Changed[c]` is set on the edge of every event for channel c.
  - It is cleared by `i_Clear[c]`=1 at a clock edge.
  - If an event and `i_Clear` hit the same channel in the same cycle, set wins.
- **Not defined:** the `i_Clear` and `o_Changed` ports and their logic are absent; all other behaviour is identical.

## Test plan
All scenarios use NUM_CH=4, DEBOUNCE_LIMIT=4, with `i_Enable`=1 unless stated otherwise.
- **Reset:** hold `i_Rst_L`=0, toggle `i_Bouncy`=4'hF → all outputs 0. Release reset → `o_Scan_Ch` steps 0,1,2,3,0.
- **Clean press:** drive `i_Bouncy[2]`=1 at edge E0 and hold → `o_Debounced[2]`=1 at an edge in E0+15…E0+18. Exactly one `o_Event_Valid` pulse, with Ch=2 and Level=1. Other bits remain 0.
- **Bounce:** drive 1,0,1 on `i_Bouncy[0]` in consecutive cycles, then return to 0 → no event, and `o_Debounced[0]` stays 0. Then 1-0-1-stable → exactly one rising event.
- **Reset mid-count:** with `i_Bouncy[1]`=1 held, assert `i_Rst_L`=0 at E0+10 → `o_Debounced` and the counters clear immediately. After release, acceptance needs a full 4 visits again.
- **Enable freeze:** with `i_Bouncy[3]`=1, drop `i_Enable` for 20 cycles mid-count → `o_Scan_Ch` holds and no event occurs. After `i_Enable` returns, the remaining visits complete and a single event fires with Ch=3.
- **Sticky (macro defined):** a channel-2 event sets `o_Changed[2]`=1. Pulsing `i_Clear[2]` clears it. `i_Clear[2]` on the same edge as a new channel-2 event leaves `o_Changed[2]`=1.
